// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide data memory with a single write enable.
// Accepts one RV32I load/store at a time. Loads are byte/half extracted and
// extended. SB/SH are read-modify-write because the memory has no byte enables.
// Misaligned, out-of-range and illegal-funct3 requests return an error response
// without touching memory.
module lsu_mem_master #(
    parameter logic [31:0] MEM_BASE  = 32'h1001_0000,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [1:0]  off_q, off_d;          // byte offset within the word
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] wdata_q, wdata_d;      // only the low half is ever merged
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    // Decide whether a request is rejected: bad funct3, misaligned, or outside memory.
    function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic        bad_f3;
        logic        misal;
        logic [31:0] offset;
        if (we) bad_f3 = f3[2] || (f3[1:0] == 2'b11);
        else    bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        misal  = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        // Unsigned wrap makes addresses below MEM_BASE look huge, so one compare covers both ends.
        offset = a - MEM_BASE;
        return bad_f3 || misal || (offset >= MEM_BYTES);
    endfunction

    // Little-endian byte/half select followed by sign or zero extension.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace one byte or half lane of the read word with the store data.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off, input logic half,
                                          input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (!half)       r[{off, 3'b000} +: 8] = d[7:0];
        else if (off[1]) r[31:16] = d;
        else             r[15:0]  = d;
        return r;
    endfunction

    // Next-state and datapath register updates for the request sequencer.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d       = req_addr[1:0];
                    funct3_d    = req_funct3;
                    wdata_d     = req_wdata[15:0];
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = req_error(req_we, req_funct3, req_addr);
                    if (rsp_err_d) begin
                        state_d = S_RESP;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (!req_we) begin
                            state_d = S_LOAD;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            mem_wdata_d = req_wdata;
                            state_d     = S_WRITE;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end
            end
            S_LOAD: begin
                rsp_rdata_d = load_ext(mem_rdata, off_q, funct3_q);
                state_d     = S_RESP;
            end
            S_RMW_RD: begin
                mem_wdata_d = merge(mem_rdata, off_q, funct3_q[0], wdata_q);
                state_d     = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-request registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            wdata_q     <= 16'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Handshake and write enable are state decodes, so reset drops them asynchronously.
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign mem_wr_en = (state_q == S_WRITE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a driver issues directed requests and
// pushes hand-computed responses/writes; monitors compare on each rsp_valid
// and mem_wr_en cycle, including latency from the accept edge.
module tb_lsu_mem_master;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t exp_q[$];
    wr_t  wq[$];

    logic [31:0] mem [0:1023];
    logic [31:0] moff;

    lsu_mem_master #(.MEM_BASE(BASE), .MEM_BYTES(4096)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on rising edge.
    always_comb begin
        moff = mem_addr - BASE;
        mem_rdata = (moff < 32'd4096) ? mem[moff[11:2]] : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_wr_en && (moff < 32'd4096)) mem[moff[11:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Response and write monitors.
    always @(negedge clk) begin
        if (rstn) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            if (mem_wr_en) begin
                if (wq.size() == 0) begin
                    chk("write_unexpected", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_wdata, w.data);
                end
            end
        end
    end

    // Present a request and hold it until accepted; leaves req_valid high.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat, input bit exp_rsp);
        bit acc;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (req_ready) begin
                if (exp_rsp) exp_q.push_back('{er, ee, cyc, lat});
                acc = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wr_exp(input logic [31:0] a, input logic [31:0] d);
        wq.push_back('{a, d});
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // Reset state
        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wr_en", {31'h0, mem_wr_en}, 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // 1: SW then LW
        wr_exp(32'h1001_0000, 32'hDEAD_BEEF);
        send(1'b1, 3'b010, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1);
        drain();
        send(1'b0, 3'b010, 32'h1001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1);
        drain();

        // 2: sub-word loads
        send(1'b0, 3'b000, 32'h1001_0003, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, 1'b1); drain();
        send(1'b0, 3'b100, 32'h1001_0003, 32'h0, 32'h0000_00DE, 1'b0, 2, 1'b1); drain();
        send(1'b0, 3'b001, 32'h1001_0002, 32'h0, 32'hFFFF_DEAD, 1'b0, 2, 1'b1); drain();
        send(1'b0, 3'b101, 32'h1001_0000, 32'h0, 32'h0000_BEEF, 1'b0, 2, 1'b1); drain();
        send(1'b0, 3'b000, 32'h1001_0000, 32'h0, 32'hFFFF_FFEF, 1'b0, 2, 1'b1); drain();

        // 3: read-modify-write byte and half
        wr_exp(32'h1001_0004, 32'h1234_5678);
        send(1'b1, 3'b010, 32'h1001_0004, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b1); drain();
        wr_exp(32'h1001_0004, 32'h1234_AA78);
        send(1'b1, 3'b000, 32'h1001_0005, 32'h0000_00AA, 32'h0, 1'b0, 3, 1'b1); drain();
        send(1'b0, 3'b010, 32'h1001_0004, 32'h0, 32'h1234_AA78, 1'b0, 2, 1'b1); drain();
        wr_exp(32'h1001_0004, 32'hCAFE_AA78);
        send(1'b1, 3'b001, 32'h1001_0006, 32'h0000_CAFE, 32'h0, 1'b0, 3, 1'b1); drain();
        send(1'b0, 3'b010, 32'h1001_0004, 32'h0, 32'hCAFE_AA78, 1'b0, 2, 1'b1); drain();

        // 4: error cases (no writes expected)
        send(1'b0, 3'b010, 32'h1001_0002, 32'h0, 32'h0, 1'b1, 1, 1'b1); drain();
        send(1'b1, 3'b001, 32'h1001_0001, 32'h0000_1111, 32'h0, 1'b1, 1, 1'b1); drain();
        send(1'b0, 3'b011, 32'h1001_0000, 32'h0, 32'h0, 1'b1, 1, 1'b1); drain();
        send(1'b0, 3'b010, 32'h1001_1000, 32'h0, 32'h0, 1'b1, 1, 1'b1); drain();
        send(1'b1, 3'b010, 32'h1000_FFFC, 32'h0000_2222, 32'h0, 1'b1, 1, 1'b1); drain();
        send(1'b1, 3'b100, 32'h1001_0000, 32'h0000_3333, 32'h0, 1'b1, 1, 1'b1); drain();

        // 5: back-to-back with req_valid held high
        wr_exp(32'h1001_0008, 32'hA5A5_0F0F);
        send(1'b1, 3'b010, 32'h1001_0008, 32'hA5A5_0F0F, 32'h0, 1'b0, 2, 1'b1);
        chk("busy_req_ready", {31'h0, req_ready}, 32'd0);
        send(1'b0, 3'b010, 32'h1001_0008, 32'h0, 32'hA5A5_0F0F, 1'b0, 2, 1'b1);
        chk("busy_req_ready2", {31'h0, req_ready}, 32'd0);
        drain();

        // 6: reset during the WRITE cycle of an SB
        wr_exp(32'h1001_0004, 32'hCAFE_AA55);
        send(1'b1, 3'b000, 32'h1001_0004, 32'h0000_0055, 32'h0, 1'b0, 3, 1'b0);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (mem_wr_en) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rmw_write_seen", {31'h0, seen}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("abort_wr_en", {31'h0, mem_wr_en}, 32'd0);
        chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'd1);
        send(1'b0, 3'b010, 32'h1001_0004, 32'h0, 32'hCAFE_AA78, 1'b0, 2, 1'b1); drain();

        chk("wr_pending", 32'(wq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store initiator that drives the word-wide data memory port (mem_addr, mem_wdata, mem_wr_en, mem_rdata) on behalf of the core.
- Accepts one RV32I load/store request at a time.
- Performs byte/halfword extraction with sign/zero extension on loads.
- Implements SB/SH as read-modify-write, because the memory has a single word write enable and no byte enables.
- Checks alignment and address range, and returns one response per request.

Parameters:
MEM_BASE, 32'h1001_0000, byte address of memory word 0
MEM_BYTES, 4096, memory size in bytes (power of 2, multiple of 4)

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr  input  32  byte address
req_wdata  input  32  store data (SB uses [7:0], SH uses [15:0])
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range, or illegal funct3
mem_addr  output  32  word-aligned byte address to memory
mem_wdata  output  32  write data to memory
mem_wr_en  output  1  memory write enable; memory writes on rising clk when high
mem_rdata  input  32  memory read data; combinational from mem_addr, same cycle

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP. Async reset forces IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_wdata=0, mem_wr_en=0.
- All outputs are registered or decoded from state only. No combinational path from req_* to mem_* or rsp_*.
- req_ready=1 only in IDLE. A request is accepted on a rising edge with req_valid & req_ready; addr, wdata, we and funct3 are captured.
- Error check at accept: error if any of the following holds:
  - funct3 illegal for the op (loads: 011/110/111; stores: anything other than 000/001/010);
  - halfword with addr[0]!=0;
  - word with addr[1:0]!=0;
  - addr outside [MEM_BASE, MEM_BASE+MEM_BYTES-1].
  On error go straight to RESP with rsp_err=1. mem_wr_en never asserts for an errored request.
- Legal transitions from IDLE:
  - load -> LOAD;
  - SW -> WRITE;
  - SB/SH -> RMW_RD.
- LOAD (1 cycle):
  - mem_addr = {addr[31:2],2'b00}, mem_wr_en=0.
  - Capture mem_rdata, select the byte/half using addr[1:0] (little-endian), extend per funct3, then go to RESP.
- RMW_RD (1 cycle): mem_addr = word address, mem_wr_en=0. Capture mem_rdata into the merge register, then go to WRITE.
- WRITE (1 cycle): mem_addr = word address, mem_wr_en=1, then go to RESP. mem_wdata is:
  - SW: req_wdata;
  - SB: the captured word with byte lane addr[1:0] replaced by wdata[7:0];
  - SH: the captured word with half lane addr[1] replaced by wdata[15:0].
- RESP (1 cycle): rsp_valid=1, rsp_rdata/rsp_err valid, then go to IDLE. No response backpressure.
- Latency from accept edge to rsp_valid high:
  - load and SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- Back-to-back: the next request can be accepted the cycle after RESP, when req_ready returns to 1.
- Outside WRITE, mem_wr_en=0. mem_addr/mem_wdata hold their last values and are don't-care to memory.
- Reset asserted mid-operation aborts immediately: mem_wr_en drops asynchronously, no response is issued, and partial RMW data is discarded.
- req_valid while busy is ignored; the requester must hold the request until accepted.

Test Plan:
1. SW addr 1001_0000 data DEADBEEF, then LW 1001_0000 -> WRITE cycle drives mem_wr_en=1, mem_addr=1001_0000, mem_wdata=DEADBEEF. Load response rsp_rdata=DEADBEEF, rsp_err=0, 2 cycles after accept.
2. With DEADBEEF at 1001_0000, LB 1001_0003 -> FFFFFFDE; LBU 1001_0003 -> 000000DE; LH 1001_0002 -> FFFFDEAD; LHU 1001_0000 -> 0000BEEF.
3. SW 1001_0004 data 12345678, then SB 1001_0005 data 000000AA, then LW 1001_0004 -> RMW writes 1234AA78 and the LW returns 1234AA78. Then SH 1001_0006 data 0000CAFE, LW 1001_0004 -> CAFEAA78.
4. LW 1001_0002, SH 1001_0001, load funct3=011, LW 1001_1000 -> each returns rsp_err=1, rsp_rdata=0, 1 cycle latency, and mem_wr_en stays 0 throughout.
5. Back-to-back: req_valid held high with SW then LW -> req_ready low while busy, exactly one rsp_valid pulse per request, in order.
6. Assert rstn=0 during the WRITE cycle of an SB -> mem_wr_en falls with no clock edge and there is no rsp_valid. After release: req_ready=1, and an LW of that address returns the original word unmodified.
